// File: rtl/matrix_load_ctrl.sv
// matrix_load_ctrl
//   Receives a framed byte stream (header byte, then DIM*DIM bytes of matrix A,
//   then DIM*DIM bytes of matrix B, both row-major), writes each element into
//   matrix memory, starts the multiplier and waits for it to finish. A load is
//   abandoned when no byte arrives for TIMEOUT cycles.
//
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   rx_data    received byte
//   rx_valid   one byte delivered per high cycle
//   mm_done    multiplier finished (single-cycle pulse)
//   wr_en      matrix memory write strobe (one cycle per accepted byte)
//   wr_sel     0 = matrix A, 1 = matrix B (held between writes)
//   wr_addr    row-major element index (held between writes)
//   wr_data    element value (held between writes)
//   mm_start   single-cycle multiplier start pulse
//   busy       high in every state except IDLE
//   hdr_err    pulse: non-header byte received while idle
//   timeout    pulse: load aborted on idle gap
//   overrun    pulse: byte dropped while starting/waiting on the multiplier
module matrix_load_ctrl #(
  parameter int unsigned DIM     = 4,
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter int unsigned TIMEOUT = 1000,
  localparam int unsigned IDX_W  = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             mm_done,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [IDX_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             mm_start,
  output logic             busy,
  output logic             hdr_err,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIM * DIM - 1);
  localparam logic [15:0]      GAP_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT_MM
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [15:0]      gap, gap_d;
  logic [15:0]      gap_inc;

  logic             wr_en_d, wr_sel_d;
  logic [IDX_W-1:0] wr_addr_d;
  logic [7:0]       wr_data_d;
  logic             mm_start_d, hdr_err_d, timeout_d, overrun_d;

  assign gap_inc = gap + 16'd1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      gap      <= '0;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mm_start <= 1'b0;
      hdr_err  <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      gap      <= gap_d;
      wr_en    <= wr_en_d;
      wr_sel   <= wr_sel_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      mm_start <= mm_start_d;
      hdr_err  <= hdr_err_d;
      timeout  <= timeout_d;
      overrun  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    gap_d      = gap;
    wr_en_d    = 1'b0;
    wr_sel_d   = wr_sel;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    mm_start_d = 1'b0;
    hdr_err_d  = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == HDR) begin
            state_d = LOAD_A;
            idx_d   = '0;
            gap_d   = '0;
          end else begin
            hdr_err_d = 1'b1;
          end
        end
      end

      LOAD_A, LOAD_B: begin
        // An arriving byte takes priority over the gap limit, so a byte in the
        // cycle the limit would be hit is still written.
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = (state == LOAD_B);
          wr_addr_d = idx;
          wr_data_d = rx_data;
          gap_d     = '0;
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state == LOAD_A) ? LOAD_B : START;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end else if (gap_inc == GAP_LIMIT) begin
          state_d   = IDLE;
          idx_d     = '0;
          gap_d     = '0;
          timeout_d = 1'b1;
        end else begin
          gap_d = gap_inc;
        end
      end

      START: begin
        mm_start_d = 1'b1;
        overrun_d  = rx_valid;
        state_d    = WAIT_MM;
      end

      WAIT_MM: begin
        overrun_d = rx_valid;
        if (mm_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// tb_matrix_load_ctrl
//   Self-checking bench for matrix_load_ctrl with DIM=2, TIMEOUT=20: a vector
//   table for a full frame plus error cases, hand-written sequences for gap
//   limit and reset corners, then randomized traffic against a reference model.
module tb_matrix_load_ctrl;

  localparam int         DIM = 2;
  localparam int         TO  = 20;
  localparam int         N2  = DIM * DIM;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       mm_done = 1'b0;
  logic       wr_en, wr_sel, mm_start, busy, hdr_err, timeout, overrun;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  int tests = 0;
  int fails = 0;

  matrix_load_ctrl #(
    .DIM    (DIM),
    .HDR    (HDR),
    .TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .mm_done (mm_done),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mm_start(mm_start),
    .busy    (busy),
    .hdr_err (hdr_err),
    .timeout (timeout),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // {wr_en, wr_sel, wr_addr, wr_data, mm_start, busy, hdr_err, timeout, overrun}
  function automatic logic [16:0] pk(input logic we, input logic sel, input logic [1:0] addr,
                                     input logic [7:0] data, input logic st, input logic bsy,
                                     input logic he, input logic to, input logic ov);
    return {we, sel, addr, data, st, bsy, he, to, ov};
  endfunction

  function automatic logic [16:0] obs();
    return {wr_en, wr_sel, wr_addr, wr_data, mm_start, busy, hdr_err, timeout, overrun};
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (we,sel,addr,data,st,busy,he,to,ov)", name, act, exp);
    end
  endtask

  // Reference model: tracks how many bytes of the current frame have arrived
  // and derives matrix select/address arithmetically from that count.
  int         m_n;      // -1 when not loading, else bytes of A+B received so far
  bit         m_start;  // frame complete, start pulse owed
  bit         m_wait;   // waiting for the multiplier
  int         m_gap;
  logic       e_we, e_sel, e_st, e_he, e_to, e_ov;
  logic [1:0] e_addr;
  logic [7:0] e_data;

  function automatic void model_reset();
    m_n = -1; m_start = 0; m_wait = 0; m_gap = 0;
    e_we = 0; e_sel = 0; e_addr = 0; e_data = 0; e_st = 0; e_he = 0; e_to = 0; e_ov = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d, input logic done);
    e_we = 0; e_st = 0; e_he = 0; e_to = 0; e_ov = 0;
    if (m_start) begin
      e_st = 1; m_start = 0; m_wait = 1;
      if (v) e_ov = 1;
    end else if (m_wait) begin
      if (v) e_ov = 1;
      if (done) m_wait = 0;
    end else if (m_n < 0) begin
      if (v) begin
        if (d == HDR) begin m_n = 0; m_gap = 0; end
        else e_he = 1;
      end
    end else if (v) begin
      e_we = 1; e_sel = (m_n >= N2); e_addr = 2'(m_n % N2); e_data = d;
      m_n++; m_gap = 0;
      if (m_n == 2 * N2) begin m_n = -1; m_start = 1; end
    end else begin
      m_gap++;
      if (m_gap == TO) begin e_to = 1; m_n = -1; m_gap = 0; end
    end
  endfunction

  function automatic logic [16:0] model_exp();
    return pk(e_we, e_sel, e_addr, e_data, e_st, (m_n >= 0) || m_start || m_wait, e_he, e_to, e_ov);
  endfunction

  // Drive one cycle of inputs (called at a negedge), let the edge happen,
  // return at the following negedge with outputs settled.
  task automatic step(input logic v, input logic [7:0] d, input logic done);
    rx_valid = v; rx_data = d; mm_done = done;
    @(posedge clk);
    model_step(v, d, done);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; mm_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        done;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[17];
  int   dens;

  initial begin
    model_reset();
    #1;
    chk("reset_state", obs(), '0);
    @(negedge clk);
    rst = 1'b0;

    // Full frame back-to-back, multiplier handshake, overrun, header error,
    // and mm_done ignored outside WAIT_MM.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, pk(0, 0, 0, 8'h00, 0, 1, 0, 0, 0)};
    tbl[1]  = '{1'b1, 8'h01, 1'b0, pk(1, 0, 0, 8'h01, 0, 1, 0, 0, 0)};
    tbl[2]  = '{1'b1, 8'h02, 1'b0, pk(1, 0, 1, 8'h02, 0, 1, 0, 0, 0)};
    tbl[3]  = '{1'b1, 8'h03, 1'b0, pk(1, 0, 2, 8'h03, 0, 1, 0, 0, 0)};
    tbl[4]  = '{1'b1, 8'h04, 1'b0, pk(1, 0, 3, 8'h04, 0, 1, 0, 0, 0)};
    tbl[5]  = '{1'b1, 8'hA5, 1'b0, pk(1, 1, 0, 8'hA5, 0, 1, 0, 0, 0)};
    tbl[6]  = '{1'b1, 8'h06, 1'b0, pk(1, 1, 1, 8'h06, 0, 1, 0, 0, 0)};
    tbl[7]  = '{1'b1, 8'h07, 1'b0, pk(1, 1, 2, 8'h07, 0, 1, 0, 0, 0)};
    tbl[8]  = '{1'b1, 8'h08, 1'b0, pk(1, 1, 3, 8'h08, 0, 1, 0, 0, 0)};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, pk(0, 1, 3, 8'h08, 1, 1, 0, 0, 0)};
    tbl[10] = '{1'b1, 8'h55, 1'b0, pk(0, 1, 3, 8'h08, 0, 1, 0, 0, 1)};
    tbl[11] = '{1'b0, 8'h00, 1'b1, pk(0, 1, 3, 8'h08, 0, 0, 0, 0, 0)};
    tbl[12] = '{1'b1, 8'h3C, 1'b0, pk(0, 1, 3, 8'h08, 0, 0, 1, 0, 0)};
    tbl[13] = '{1'b0, 8'h00, 1'b0, pk(0, 1, 3, 8'h08, 0, 0, 0, 0, 0)};
    tbl[14] = '{1'b0, 8'h00, 1'b1, pk(0, 1, 3, 8'h08, 0, 0, 0, 0, 0)};
    tbl[15] = '{1'b1, 8'hA5, 1'b0, pk(0, 1, 3, 8'h08, 0, 1, 0, 0, 0)};
    tbl[16] = '{1'b0, 8'h00, 1'b1, pk(0, 1, 3, 8'h08, 0, 1, 0, 0, 0)};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].done);
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Gap limit: 19 idle cycles keep loading, the 20th aborts.
    do_reset();
    step(1'b1, HDR, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    chk("to_w0", obs(), pk(1, 0, 0, 8'h11, 0, 1, 0, 0, 0));
    step(1'b1, 8'h22, 1'b0);
    chk("to_w1", obs(), pk(1, 0, 1, 8'h22, 0, 1, 0, 0, 0));
    idle(TO - 1);
    chk("to_gap19", obs(), pk(0, 0, 1, 8'h22, 0, 1, 0, 0, 0));
    idle(1);
    chk("to_fire", obs(), pk(0, 0, 1, 8'h22, 0, 0, 0, 1, 0));
    idle(1);
    chk("to_pulse_end", obs(), pk(0, 0, 1, 8'h22, 0, 0, 0, 0, 0));
    step(1'b1, HDR, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("to_reload_a0", obs(), pk(1, 0, 0, 8'h33, 0, 1, 0, 0, 0));
    // A byte in the cycle the limit would be hit wins and restarts the gap.
    idle(TO - 1);
    step(1'b1, 8'h44, 1'b0);
    chk("to_byte_wins", obs(), pk(1, 0, 1, 8'h44, 0, 1, 0, 0, 0));
    idle(TO - 1);
    chk("to_regap19", obs(), pk(0, 0, 1, 8'h44, 0, 1, 0, 0, 0));
    idle(1);
    chk("to_refire", obs(), pk(0, 0, 1, 8'h44, 0, 0, 0, 1, 0));

    // Asynchronous reset mid-load, then a fresh frame must start with HDR.
    do_reset();
    step(1'b1, HDR, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst", obs(), '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 8'h03, 1'b0);
    chk("rst_needs_hdr", obs(), pk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    step(1'b1, HDR, 1'b0);
    for (int i = 1; i <= 2 * N2; i++) step(1'b1, 8'(i), 1'b0);
    chk("rst_reload_b3", obs(), pk(1, 1, 3, 8'h08, 0, 1, 0, 0, 0));
    step(1'b1, 8'h99, 1'b0);
    chk("rst_reload_start", obs(), pk(0, 1, 3, 8'h08, 1, 1, 0, 0, 1));
    step(1'b0, 8'h00, 1'b1);
    chk("rst_reload_done", obs(), pk(0, 1, 3, 8'h08, 0, 0, 0, 0, 0));

    // Randomized traffic against the reference model.
    do_reset();
    dens = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 100;
          1: dens = 70;
          2: dens = 30;
          default: dens = 3;
        endcase
      end
      if ($urandom_range(0, 499) == 0) begin
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rnd_async_rst", obs(), '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end else begin
        step(int'($urandom_range(0, 99)) < dens,
             ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom),
             $urandom_range(0, 9) == 0);
        chk($sformatf("rnd%0d", c), obs(), model_exp());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
